sobel_gradient: RTL and testbench

Downstream neighbour of `five_by_five_window`: consumes its Gaussian-blurred 8-bit pixel stream (`dout`/`blanking_out`/`validout`) and produces an 8-bit Sobel gradient-magnitude stream in the same raster/blanking format. It uses two line buffers and a 3x3 window to compute |Gx|+|Gy|, scales and saturates the result, and forwards blanking with matched latency. This stage is the edge-strength input to the feature-detection stages that follow.

---
 rtl/sobel_gradient.sv | 156 +++++++++++++++
 tb/tb_sobel_gradient.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_gradient.sv
// rtl/sobel_gradient.sv - Sobel |Gx|+|Gy| gradient magnitude over a raster pixel stream
module sobel_gradient #(
   parameter int ACTIVE = 400,
   parameter int BLANK  = 20,
   parameter int SHIFT  = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] din,
   input  logic       blanking_in,
   input  logic       validin,
   output logic [7:0] dout,
   output logic       blanking_out,
   output logic       validout
);

   localparam int LINE = ACTIVE + BLANK;
   localparam int AW   = $clog2(LINE);
   localparam int FW   = $clog2(LINE + 2);
   localparam int CW   = $clog2(LINE + 1);

   localparam logic [AW-1:0] ADDR_LAST = AW'(LINE - 1);
   localparam logic [FW-1:0] FILL_MAX  = FW'(LINE + 1);
   localparam logic [CW-1:0] COL_LAST  = CW'(ACTIVE - 1);

   // Line buffers: lb0 holds the previous line with its blanking flag, lb1 the line before it.
   logic [8:0] lb0 [LINE];
   logic [7:0] lb1 [LINE];

   logic [AW-1:0] addr;
   logic [FW-1:0] fill;
   logic [CW-1:0] col;
   logic          row0;

   logic [8:0] tap1;
   logic [7:0] tap2;

   // Window: columns 0 and 1 are registered, column 2 is the sample being accepted now.
   logic [7:0] p00, p10, p20;
   logic [7:0] p01, p11, p21;
   logic [7:0] p02, p12, p22;
   logic       ctr_blank;

   logic        full;
   logic        centre_zero;
   logic [9:0]  gx_pos, gx_neg, gy_pos, gy_neg;
   logic [10:0] gx, gy;

   logic        s1_valid, s1_blank, s1_zero;
   logic [10:0] s1_gx, s1_gy;

   logic [10:0] abs_gx, abs_gy;
   logic [11:0] mag;
   logic [11:0] shifted;
   logic [7:0]  sat;

   assign tap1 = lb0[addr];
   assign tap2 = lb1[addr];

   assign p02 = tap2;
   assign p12 = tap1[7:0];
   assign p22 = din;

   assign full        = (fill == FILL_MAX);
   assign centre_zero = ctr_blank | (col == '0) | (col == COL_LAST) | row0;

   assign gx_pos = {2'b00, p02} + {1'b0, p12, 1'b0} + {2'b00, p22};
   assign gx_neg = {2'b00, p00} + {1'b0, p10, 1'b0} + {2'b00, p20};
   assign gy_pos = {2'b00, p20} + {1'b0, p21, 1'b0} + {2'b00, p22};
   assign gy_neg = {2'b00, p00} + {1'b0, p01, 1'b0} + {2'b00, p02};
   assign gx     = {1'b0, gx_pos} - {1'b0, gx_neg};
   assign gy     = {1'b0, gy_pos} - {1'b0, gy_neg};

   assign abs_gx  = s1_gx[10] ? (~s1_gx + 11'd1) : s1_gx;
   assign abs_gy  = s1_gy[10] ? (~s1_gy + 11'd1) : s1_gy;
   assign mag     = {1'b0, abs_gx} + {1'b0, abs_gy};
   assign shifted = mag >> SHIFT;
   assign sat     = (shifted > 12'd255) ? 8'hFF : shifted[7:0];

   // Line buffer write after read at the shared address; contents survive reset.
   always_ff @(posedge clock) begin
      if (validin && !reset) begin
         lb0[addr] <= {blanking_in, din};
         lb1[addr] <= tap1[7:0];
      end
   end

   // Shift the window one column left on every accepted sample.
   always_ff @(posedge clock) begin
      if (validin && !reset) begin
         p00       <= p01;
         p10       <= p11;
         p20       <= p21;
         p01       <= p02;
         p11       <= p12;
         p21       <= p22;
         ctr_blank <= tap1[8];
      end
   end

   // Address, fill, centre-column and first-line tracking.
   always_ff @(posedge clock) begin
      if (reset) begin
         addr <= '0;
         fill <= '0;
         col  <= '0;
         row0 <= 1'b1;
      end else if (validin) begin
         addr <= (addr == ADDR_LAST) ? '0 : addr + 1'b1;
         if (!full) begin
            fill <= fill + 1'b1;
         end
         if (full) begin
            if (ctr_blank) begin
               col <= '0;
               if (col != '0) begin
                  row0 <= 1'b0;
               end
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   // Stage 1: capture the signed gradients and the output tag.
   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_blank <= 1'b0;
         s1_zero  <= 1'b0;
         s1_gx    <= '0;
         s1_gy    <= '0;
      end else begin
         s1_valid <= validin & full;
         s1_blank <= ctr_blank;
         s1_zero  <= centre_zero;
         s1_gx    <= gx;
         s1_gy    <= gy;
      end
   end

   // Stage 2: magnitude, scale and saturate, with forced zero on borders and blanking.
   always_ff @(posedge clock) begin
      if (reset) begin
         dout         <= '0;
         blanking_out <= 1'b0;
         validout     <= 1'b0;
      end else begin
         validout     <= s1_valid;
         blanking_out <= s1_valid & s1_blank;
         dout         <= (s1_valid && !s1_zero) ? sat : 8'd0;
      end
   end

endmodule

// File: tb/tb_sobel_gradient.sv
// tb/tb_sobel_gradient.sv - directed table-driven bench for sobel_gradient
module tb_sobel_gradient;

   localparam int ACTIVE = 400;
   localparam int BLANK  = 20;
   localparam int LINE   = ACTIVE + BLANK;

   typedef struct {
      int pat;        // 0 uniform, 1 vertical step, 2 horizontal ramp
      int amp;
      bit shift0;     // observe the SHIFT=0 instance
      bit toggle;     // validin 1/0 alternating
      int nlines;
      int edge_val;   // expected dout at step edge cols / ramp cols 1..254
      int edge_tail;  // expected dout at ramp col 255
      int first_lat;  // cycles from first sample to first validout
      int out_count;  // expected number of valid outputs
   } vec_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] din = 8'd0;
   logic       blanking_in = 1'b0;
   logic       validin = 1'b0;

   logic [7:0] dout_a, dout_b;
   logic       blank_a, blank_b, valid_a, valid_b;
   logic       sel_b = 1'b0;
   logic [7:0] dout;
   logic       blanking_out, validout;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   int  pres_q[$];
   bit  mon_en = 1'b0;
   int  out_idx, bad_dout, bad_blank, bad_time, first_out;
   int  fb_j, fb_got, fb_want;
   vec_t cur;
   vec_t tests[6];
   string names[6];

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   sobel_gradient #(.ACTIVE(ACTIVE), .BLANK(BLANK), .SHIFT(2)) dut_a (
      .clock(clock), .reset(reset), .din(din), .blanking_in(blanking_in), .validin(validin),
      .dout(dout_a), .blanking_out(blank_a), .validout(valid_a));

   sobel_gradient #(.ACTIVE(ACTIVE), .BLANK(BLANK), .SHIFT(0)) dut_b (
      .clock(clock), .reset(reset), .din(din), .blanking_in(blanking_in), .validin(validin),
      .dout(dout_b), .blanking_out(blank_b), .validout(valid_b));

   assign dout         = sel_b ? dout_b  : dout_a;
   assign blanking_out = sel_b ? blank_b : blank_a;
   assign validout     = sel_b ? valid_b : valid_a;

   function automatic logic [7:0] pix(input int pat, input int amp, input int pos);
      if (pos >= ACTIVE) return 8'd0;
      case (pat)
         0: return 8'(amp);
         1: return (pos >= 200) ? 8'(amp) : 8'd0;
         2: return (pos < 255) ? 8'(pos) : 8'd255;
         default: return 8'd0;
      endcase
   endfunction

   function automatic int exp_pix(input vec_t v, input int j);
      int pos;
      int row;
      pos = j % LINE;
      row = j / LINE;
      if (row == 0 || pos >= ACTIVE || pos == 0 || pos == ACTIVE - 1) return 0;
      case (v.pat)
         1: return (pos == 199 || pos == 200) ? v.edge_val : 0;
         2: begin
            if (pos <= 254) return v.edge_val;
            if (pos == 255) return v.edge_tail;
            return 0;
         end
         default: return 0;
      endcase
   endfunction

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   // Output monitor: the j-th valid output belongs to centre sample j.
   always @(negedge clock) begin
      int j;
      if (mon_en && validout) begin
         j = out_idx;
         if (j == 0) first_out = cyc;
         if (j + LINE + 1 >= pres_q.size()) begin
            bad_time++;
         end else begin
            if (cyc != pres_q[j + LINE + 1] + 2) bad_time++;
            if (int'(dout) != exp_pix(cur, j)) begin
               if (bad_dout == 0) begin
                  fb_j = j;
                  fb_got = int'(dout);
                  fb_want = exp_pix(cur, j);
               end
               bad_dout++;
            end
            if (blanking_out != ((j % LINE) >= ACTIVE)) bad_blank++;
         end
         out_idx++;
      end
   end

   task automatic mon_clear();
      pres_q.delete();
      out_idx = 0;
      bad_dout = 0;
      bad_blank = 0;
      bad_time = 0;
      first_out = -1;
      fb_j = -1;
      fb_got = 0;
      fb_want = 0;
   endtask

   task automatic do_reset(input string tname);
      @(posedge clock); #1;
      reset = 1'b1;
      validin = 1'b0;
      @(posedge clock);
      @(negedge clock);
      check({tname, " reset_dout"}, int'(dout), 0);
      check({tname, " reset_validout"}, int'(validout), 0);
      check({tname, " reset_blanking_out"}, int'(blanking_out), 0);
   endtask

   task automatic drive_stream(input int pat, input int amp, input int nsamp, input bit toggle);
      int k;
      int ph;
      int pos;
      k = 0;
      ph = 0;
      while (k < nsamp) begin
         @(posedge clock); #1;
         reset = 1'b0;
         if (toggle && (ph % 2 == 1)) begin
            validin = 1'b0;
         end else begin
            pos = k % LINE;
            din = pix(pat, amp, pos);
            blanking_in = (pos >= ACTIVE);
            validin = 1'b1;
            pres_q.push_back(cyc);
            k++;
         end
         ph++;
      end
      @(posedge clock); #1;
      validin = 1'b0;
      din = 8'd0;
      blanking_in = 1'b0;
   endtask

   task automatic stream_checks(input string tname, input int want_lat, input int want_cnt);
      check({tname, " first_validout_latency"}, first_out - pres_q[0], want_lat);
      check({tname, " output_count"}, out_idx, want_cnt);
      check({tname, " output_timing_errors"}, bad_time, 0);
      check($sformatf("%s dout_errors (first centre %0d got %0d want %0d)", tname, fb_j, fb_got, fb_want),
            bad_dout, 0);
      check({tname, " blanking_out_errors"}, bad_blank, 0);
   endtask

   task automatic run_test(input vec_t v, input string tname);
      sel_b = v.shift0;
      cur = v;
      do_reset(tname);
      mon_clear();
      mon_en = 1'b1;
      drive_stream(v.pat, v.amp, v.nlines * LINE, v.toggle);
      repeat (4) @(posedge clock);
      @(negedge clock);
      mon_en = 1'b0;
      stream_checks(tname, v.first_lat, v.out_count);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tests[0] = '{0, 128, 1'b0, 1'b0, 3,   0, 0, 423, 839};
      tests[1] = '{1, 255, 1'b0, 1'b0, 3, 255, 0, 423, 839};
      tests[2] = '{2,   0, 1'b0, 1'b0, 3,   2, 1, 423, 839};
      tests[3] = '{2,   0, 1'b0, 1'b1, 3,   2, 1, 844, 839};
      tests[4] = '{1,  40, 1'b1, 1'b0, 3, 160, 0, 423, 839};
      tests[5] = '{1, 100, 1'b1, 1'b0, 3, 255, 0, 423, 839};
      names[0] = "uniform128";
      names[1] = "vstep255";
      names[2] = "hramp";
      names[3] = "hramp_toggle";
      names[4] = "shift0_step40";
      names[5] = "shift0_step100";

      for (int t = 0; t < 6; t++) begin
         run_test(tests[t], names[t]);
      end

      // Reset pulsed mid-frame while a step stream is running, then re-prime with a ramp.
      sel_b = 1'b0;
      cur = tests[1];
      do_reset("midreset");
      mon_clear();
      mon_en = 1'b1;
      drive_stream(1, 255, 5000, 1'b0);
      reset = 1'b1;
      mon_en = 1'b0;
      check("midreset pre_step_output_count", out_idx, 4577);
      check($sformatf("midreset pre_step_dout_errors (first centre %0d got %0d want %0d)", fb_j, fb_got, fb_want),
            bad_dout, 0);
      check("midreset pre_step_timing_errors", bad_time, 0);
      @(negedge clock);
      check("midreset validout_before_reset_edge", int'(validout), 1);
      @(negedge clock);
      check("midreset validout_after_reset", int'(validout), 0);
      check("midreset dout_after_reset", int'(dout), 0);
      check("midreset blanking_out_after_reset", int'(blanking_out), 0);
      cur = tests[2];
      mon_clear();
      mon_en = 1'b1;
      drive_stream(2, 0, 3 * LINE, 1'b0);
      repeat (4) @(posedge clock);
      @(negedge clock);
      mon_en = 1'b0;
      stream_checks("midreset_reprime", 423, 839);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
